des_round_ctrl: RTL

//  Iterative DES engine controller: accepts a 64-bit block + 64-bit key, applies IP/PC-1, sequences
//  16 Feistel rounds through an external f-function (E, S-boxes, P), generates round keys, and

---
 rtl/des_round_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/des_round_ctrl.sv
// Iterative DES controller: IP/PC-1 on accept, 16 Feistel rounds through an external
// f-function with on-the-fly round keys, FP(R16,L16) on completion.
module des_round_ctrl #(
  parameter int F_LATENCY = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        s_decrypt,
  input  logic [63:0] s_block,
  input  logic [63:0] s_key,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [63:0] m_block,
  output logic [31:0] f_r_o,
  output logic [47:0] f_k_o,
  input  logic [31:0] f_out_i,
  output logic [3:0]  round_o,
  output logic        busy_o
);

  // Tables use FIPS bit numbering: bit 1 is the MSB of the source vector.
  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};
  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};
  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};
  // Bit i set when the shift schedule entry for round i is 2 (otherwise 1).
  localparam logic [15:0] SHIFT2 = 16'b0111_1110_1111_1100;

  typedef enum logic [1:0] {IDLE, ROUND, WAIT, DONE} state_t;

  state_t      state_reg, state_next;
  logic [31:0] l_reg, r_reg;
  logic [27:0] c_reg, d_reg;
  logic [3:0]  round_reg;
  logic        decrypt_reg;
  logic [63:0] block_reg;

  logic [63:0] ip_blk;
  logic [55:0] pc1_key;
  logic [27:0] c_rot, d_rot;
  logic [55:0] cd_rot;
  logic [47:0] round_key;
  logic [31:0] r_new;
  logic [63:0] fp_in, fp_out;
  logic [3:0]  dec_idx;
  logic        two_shift, step, last_round;

  genvar gi;
  generate
    for (gi = 0; gi < 64; gi++) begin : g_ip
      assign ip_blk[63-gi] = s_block[64-IP_T[gi]];
      assign fp_out[63-gi] = fp_in[64-FP_T[gi]];
    end
    for (gi = 0; gi < 56; gi++) begin : g_pc1
      assign pc1_key[55-gi] = s_key[64-PC1_T[gi]];
    end
    for (gi = 0; gi < 48; gi++) begin : g_pc2
      assign round_key[47-gi] = cd_rot[56-PC2_T[gi]];
    end
  endgenerate

  // Decryption walks the schedule backwards: round i undoes shift S[16-i].
  always_comb begin
    dec_idx   = 4'd0 - round_reg;
    two_shift = decrypt_reg ? SHIFT2[dec_idx] : SHIFT2[round_reg];
    c_rot     = c_reg;
    d_rot     = d_reg;
    if (!decrypt_reg) begin
      if (two_shift) begin
        c_rot = {c_reg[25:0], c_reg[27:26]};
        d_rot = {d_reg[25:0], d_reg[27:26]};
      end else begin
        c_rot = {c_reg[26:0], c_reg[27]};
        d_rot = {d_reg[26:0], d_reg[27]};
      end
    end else if (round_reg != 4'd0) begin
      if (two_shift) begin
        c_rot = {c_reg[1:0], c_reg[27:2]};
        d_rot = {d_reg[1:0], d_reg[27:2]};
      end else begin
        c_rot = {c_reg[0], c_reg[27:1]};
        d_rot = {d_reg[0], d_reg[27:1]};
      end
    end
  end

  assign cd_rot     = {c_rot, d_rot};
  assign r_new      = l_reg ^ f_out_i;
  assign fp_in      = {r_new, r_reg};
  assign last_round = (round_reg == 4'd15);
  assign step       = (F_LATENCY == 0) ? (state_reg == ROUND) : (state_reg == WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (s_valid) state_next = ROUND;
      ROUND: begin
        if (F_LATENCY != 0)  state_next = WAIT;
        else if (last_round) state_next = DONE;
      end
      WAIT:  state_next = last_round ? DONE : ROUND;
      DONE:  if (m_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_reg       <= '0;
      r_reg       <= '0;
      c_reg       <= '0;
      d_reg       <= '0;
      round_reg   <= '0;
      decrypt_reg <= 1'b0;
      block_reg   <= '0;
    end else if (state_reg == IDLE && s_valid) begin
      l_reg       <= ip_blk[63:32];
      r_reg       <= ip_blk[31:0];
      c_reg       <= pc1_key[55:28];
      d_reg       <= pc1_key[27:0];
      decrypt_reg <= s_decrypt;
      round_reg   <= '0;
    end else if (step) begin
      l_reg <= r_reg;
      r_reg <= r_new;
      c_reg <= c_rot;
      d_reg <= d_rot;
      if (last_round) block_reg <= fp_out;
      else            round_reg <= round_reg + 4'd1;
    end
  end

  assign s_ready = (state_reg == IDLE);
  assign m_valid = (state_reg == DONE);
  assign busy_o  = (state_reg == ROUND) || (state_reg == WAIT);
  assign m_block = block_reg;
  assign f_r_o   = r_reg;
  assign f_k_o   = round_key;
  assign round_o = round_reg;

endmodule
